// File: rtl/inst_issuer.sv
`default_nettype none
// ============================================================================
// Module      : inst_issuer
// Description : Issues 32-bit instruction words from a small loadable program
//               memory under a valid/ready handshake. Inserts a one-cycle
//               bubble after every lw and stops on HALT, an illegal opcode or
//               the last memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_issuer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          start,
    output logic [31:0]   Inst,
    output logic          inst_valid,
    input  logic          inst_ready,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW:0]   issue_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_BUBBLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [5:0]    OP_HALT   = 6'd0;
    localparam logic [5:0]    OP_LW     = 6'd2;
    localparam logic [5:0]    OP_MAX    = 6'd6;

    logic [31:0]   mem_q [DEPTH];
    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [31:0]   word_w;
    logic [5:0]    opcode_w;
    logic          mem_we_w;
    logic          valid_w;

    // The word at the current pc is what gets offered; its opcode steers the FSM.
    assign word_w   = mem_q[pc_q];
    assign opcode_w = word_w[31:26];

    // Program writes are only accepted while the sequencer is parked.
    assign mem_we_w = load_en && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Program memory: no reset, so a loaded program survives a reset.
    always_ff @(posedge clk) begin
        if (mem_we_w) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // State, program counter, issue counter and sticky error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state and handshake logic; a stalled handshake holds everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        valid_w = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    pc_d    = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (opcode_w == OP_HALT) begin
                    state_d = ST_DONE;
                end else if (opcode_w > OP_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    valid_w = 1'b1;
                    if (inst_ready) begin
                        cnt_d = cnt_q + (AW+1)'(1);
                        if (pc_q == LAST_ADDR) begin
                            state_d = ST_DONE;
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = (opcode_w == OP_LW) ? ST_BUBBLE : ST_RUN;
                        end
                    end
                end
            end
            ST_BUBBLE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign inst_valid = valid_w;
    assign Inst       = valid_w ? word_w : 32'd0;
    assign pc         = pc_q;
    assign busy       = (state_q == ST_RUN) || (state_q == ST_BUBBLE);
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;
    assign issue_cnt  = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_issuer
// Description : Scoreboard bench for inst_issuer. A reference walk of the
//               bench's own program copy queues the expected issue stream,
//               which is popped on every observed handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_issuer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    localparam logic [31:0] W_ADD  = 32'h0443_0820;
    localparam logic [31:0] W_SUB  = 32'h0C43_0820;
    localparam logic [31:0] W_AND  = 32'h1443_0820;
    localparam logic [31:0] W_OR   = 32'h1843_0820;
    localparam logic [31:0] W_HALT = 32'h0000_0000;
    localparam logic [31:0] W_LW   = 32'h0841_0000;
    localparam logic [31:0] W_SW   = 32'h1041_0000;
    localparam logic [31:0] W_ILL  = 32'h1C00_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          start;
    logic [31:0]   Inst;
    logic          inst_valid;
    logic          inst_ready;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   issue_cnt;

    logic [31:0]   tb_mem [DEPTH];
    logic [31:0]   exp_q [$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [AW-1:0] exp_pc;
    int            exp_cnt;
    logic          exp_err;
    logic [31:0]   exp_pat;
    int            exp_len;
    logic [31:0]   hist;
    int            hist_len;

    always #5 clk = ~clk;

    inst_issuer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .start      (start),
        .Inst       (Inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .issue_cnt  (issue_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Sample the current cycle (1 time unit after the edge), score any
    // handshake, then advance to just after the next rising edge.
    task automatic tick();
        if (busy === 1'b1) begin
            hist = {hist[30:0], inst_valid};
            hist_len++;
        end
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_val("issue_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check_val("issue_word", Inst, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tb_mem[addr] = data;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_straight();
        load_word(0, W_ADD);
        load_word(1, W_SUB);
        load_word(2, W_AND);
        load_word(3, W_OR);
        load_word(4, W_HALT);
    endtask

    // Reference walk of the program assuming the consumer is always ready.
    task automatic model_run();
        int   a;
        logic stop;
        logic [31:0] w;
        logic [5:0]  op;
        a = 0; stop = 1'b0;
        exp_cnt = 0; exp_err = 1'b0; exp_pat = '0; exp_len = 0; exp_pc = '0;
        while (!stop) begin
            w  = tb_mem[a];
            op = w[31:26];
            if (op == 6'd0 || op > 6'd6) begin
                exp_err = (op != 6'd0);
                exp_pat = {exp_pat[30:0], 1'b0};
                exp_len++;
                exp_pc  = AW'(a);
                stop    = 1'b1;
            end else begin
                exp_q.push_back(w);
                exp_cnt++;
                exp_pat = {exp_pat[30:0], 1'b1};
                exp_len++;
                if (a == DEPTH - 1) begin
                    exp_pc = AW'(a);
                    stop   = 1'b1;
                end else begin
                    if (op == 6'd2) begin
                        exp_pat = {exp_pat[30:0], 1'b0};
                        exp_len++;
                    end
                    a++;
                end
            end
        end
    endtask

    task automatic start_prog();
        model_run();
        hist     = '0;
        hist_len = 0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        int i;
        i = 0;
        while (done !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
        check_val("done_reached", 32'(done), 32'd1);
    endtask

    task automatic finish_run(input logic chk_pat);
        check_val("final_pc", 32'(pc), 32'(exp_pc));
        check_val("final_cnt", 32'(issue_cnt), 32'(exp_cnt));
        check_val("final_err", 32'(err), 32'(exp_err));
        check_val("final_busy", 32'(busy), 32'd0);
        check_val("queue_drained", 32'(exp_q.size()), 32'd0);
        if (chk_pat) begin
            check_val("valid_len", 32'(hist_len), 32'(exp_len));
            check_val("valid_pat", hist, exp_pat);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_inst"},  Inst, 32'd0);
        check_val({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check_val({tag, "_pc"},    32'(pc), 32'd0);
        check_val({tag, "_cnt"},   32'(issue_cnt), 32'd0);
        check_val({tag, "_err"},   32'(err), 32'd0);
        check_val({tag, "_busy"},  32'(busy), 32'd0);
        check_val({tag, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        load_en    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        start      = 1'b0;
        inst_ready = 1'b1;
        hist       = '0;
        hist_len   = 0;
        for (int i = 0; i < DEPTH; i++) tb_mem[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();

        // Straight program: four back-to-back issues then HALT.
        load_straight();
        start_prog();
        run_to_done(100);
        finish_run(1'b1);

        // lw followed by sw: valid pattern 1,0,1 then HALT.
        load_word(0, W_LW);
        load_word(1, W_SW);
        load_word(2, W_HALT);
        start_prog();
        run_to_done(100);
        finish_run(1'b1);

        // Backpressure on the second word for three cycles.
        load_straight();
        start_prog();
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("bp_inst_hold", Inst, W_SUB);
            check_val("bp_pc_hold", 32'(pc), 32'd1);
            tick();
        end
        inst_ready = 1'b1;
        check_val("bp_inst_hold", Inst, W_SUB);
        check_val("bp_pc_hold", 32'(pc), 32'd1);
        run_to_done(100);
        finish_run(1'b0);

        // Every word issuable: stops at the last address.
        for (int i = 0; i < DEPTH; i++) load_word(i, W_ADD);
        start_prog();
        run_to_done(100);
        finish_run(1'b1);

        // Illegal opcode in word 1.
        load_word(1, W_ILL);
        start_prog();
        run_to_done(100);
        finish_run(1'b1);

        // Restart from DONE clears err/count; mid-run start and load ignored.
        load_straight();
        start_prog();
        check_val("start_clr_err", 32'(err), 32'd0);
        check_val("start_clr_cnt", 32'(issue_cnt), 32'd0);
        check_val("start_pc", 32'(pc), 32'd0);
        tick();
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = AW'(2);
        load_data = W_HALT;
        tick();
        start     = 1'b0;
        load_en   = 1'b0;
        run_to_done(100);
        finish_run(1'b1);

        // Rerun without reloading: memory must be intact.
        start_prog();
        run_to_done(100);
        finish_run(1'b1);

        // Asynchronous reset during the second instruction.
        start_prog();
        tick();
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        start_prog();
        check_val("rerun_pc0", 32'(pc), 32'd0);
        check_val("rerun_inst0", Inst, W_ADD);
        run_to_done(100);
        finish_run(1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
